trb_mem_port: RTL
=================

# trb_mem_port

Memory-side responder for the trace buffer's word-exchange handshake. Serves the tracer's level-held read/write request: commits the outgoing trace word, fetches the next word, and returns it with a one-cycle acknowledge. Sits between the tracer and the trace RAM, and also gives the system interface a low-priority read port for draining captured traces.

## Interface
- TRB_WIDTH, 32: memory word width in bits.
- TRB_DEPTH, 16: number of words; address width AW = $clog2(TRB_DEPTH).
- FPGA_CLK_I  in  1  sole clock; all state updates on rising edge.
- RST_  in  1  reset, asynchronous, active-low.
- RW_I  in  1  tracer exchange request; level, held high until ACK_O is seen.
- WRITE_ADDR_I  in  AW  address at which WDATA_I is stored.
- READ_ADDR_I  in  AW  address of the word returned on RDATA_O.
- WDATA_I  in  TRB_WIDTH  trace word from the tracer.
- RDATA_O  out  TRB_WIDTH  fetched word; registered; stable from ACK_O until the next fetch.
- ACK_O  out  1  single-cycle pulse; exchange complete, RDATA_O valid.
- HOST_REQ_I  in  1  host read request; level, held until HOST_VALID_O.
- HOST_ADDR_I  in  AW  host read address.
- HOST_DATA_O  out  TRB_WIDTH  host read data; registered.
- HOST_VALID_O  out  1  single-cycle pulse; HOST_DATA_O valid.
- ERR_O  out  1  sticky protocol error flag (see Configuration).

## Operation
- Storage: TRB_DEPTH x TRB_WIDTH array, single port, one access per cycle. Contents are not reset.
- States: IDLE, WRITE, READ, ACK, RELEASE, HOST.
- IDLE: if RW_I=1, go to WRITE; tracer has priority. Else if HOST_REQ_I=1, go to HOST. Else stay.
- WRITE: mem[WRITE_ADDR_I] <= WDATA_I. Go to READ.
- READ: RDATA_O <= mem[READ_ADDR_I]. Go to ACK.
- ACK: ACK_O=1 for this cycle only. Go to RELEASE.
- RELEASE: wait for RW_I=0, then go to IDLE. This prevents servicing one held request twice.
- HOST: HOST_DATA_O <= mem[HOST_ADDR_I]; HOST_VALID_O=1 in the following cycle; go to IDLE.
- Addresses are sampled in WRITE and READ respectively; the tracer must hold them stable while RW_I is high.
- Read-after-write on the same address: RDATA_O returns the word just written (write precedes read).
- Out-of-range address (>= TRB_DEPTH, non-power-of-2 depth only):
  - write is dropped;
  - read returns all zeros;
  - the handshake still completes.
- RW_I dropping before ACK: the exchange still runs to ACK and then returns to IDLE through RELEASE. Any write already performed stays committed.
- Reset: asynchronous, at any point.
  - State returns to IDLE; no ACK_O is issued for the aborted exchange.
  - RDATA_O=0, ACK_O=0, HOST_DATA_O=0, HOST_VALID_O=0, ERR_O=0.
  - Memory retains any completed writes.

## Timing
- RW_I sampled high at edge N: write at edge N+1, read at edge N+2, ACK_O high during cycle N+2..N+3.
- Result: 3-cycle request-to-ACK latency and a minimum of 4 cycles between exchanges (RELEASE sees RW_I=0 one cycle after ACK).
- Tracer must raise RW_I at least 4 cycles before it needs the new word.
- HOST_REQ_I sampled high at edge N in IDLE: HOST_VALID_O high during cycle N+1..N+2.
- Host latency is unbounded under continuous tracer traffic: at most one host read between tracer exchanges.
- Simultaneous RW_I and HOST_REQ_I in IDLE: tracer served first; host served after the tracer returns to IDLE, provided HOST_REQ_I is still high.

## Configuration
- TRB_MEM_ERR_EN defined: ERR_O is set, sticky until reset, when any of these occurs:
  - RW_I low while in WRITE or READ (request abort);
  - out-of-range address on any access;
  - RW_I low for one cycle then high again while in RELEASE before IDLE is reached.
- TRB_MEM_ERR_EN undefined: ERR_O is tied to 0 and no detection logic is built.

## Test plan
- Reset, write/fetch: reset, preload mem[3]=32'hA5A5_0003; RW_I=1, WRITE_ADDR_I=2, WDATA_I=32'hDEAD_BEEF, READ_ADDR_I=3 → ACK_O pulses 3 cycles later, RDATA_O=32'hA5A5_0003; host read of address 2 returns 32'hDEAD_BEEF.
- Read-after-write: WRITE_ADDR_I=READ_ADDR_I=5, WDATA_I=32'h1234_5678 → RDATA_O=32'h1234_5678 at ACK.
- Held request: RW_I held high 10 cycles after ACK → exactly one ACK_O pulse; next ACK only after RW_I toggles low then high.
- Arbitration: RW_I and HOST_REQ_I (addr 0) rise together → ACK_O first, HOST_VALID_O after return to IDLE, HOST_DATA_O=mem[0].
- Reset mid-exchange: RST_ low during READ → all outputs 0 immediately, no ACK_O; after release, mem[WRITE_ADDR_I] holds the new word.
- TRB_MEM_ERR_EN defined, TRB_DEPTH=12: access to address 13 → ERR_O=1 and stays 1; RDATA_O=0. Undefined: ERR_O=0 throughout.

Source files
------------

// File: rtl/trb_mem_port.sv
// Trace-buffer memory responder: serves the tracer's level-held write+fetch exchange
// and a low-priority host read port. Define TRB_MEM_ERR_EN to build the sticky ERR_O detector.
module trb_mem_port #(
  parameter int TRB_WIDTH = 32,
  parameter int TRB_DEPTH = 16,
  localparam int AW = (TRB_DEPTH > 1) ? $clog2(TRB_DEPTH) : 1
) (
  input  logic                 FPGA_CLK_I,
  input  logic                 RST_,
  input  logic                 RW_I,
  input  logic [AW-1:0]        WRITE_ADDR_I,
  input  logic [AW-1:0]        READ_ADDR_I,
  input  logic [TRB_WIDTH-1:0] WDATA_I,
  output logic [TRB_WIDTH-1:0] RDATA_O,
  output logic                 ACK_O,
  input  logic                 HOST_REQ_I,
  input  logic [AW-1:0]        HOST_ADDR_I,
  output logic [TRB_WIDTH-1:0] HOST_DATA_O,
  output logic                 HOST_VALID_O,
  output logic                 ERR_O
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(TRB_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_ACK, S_RELEASE, S_HOST
  } state_t;

  typedef struct packed {
    logic                 we;
    logic [AW-1:0]        addr;
    logic [TRB_WIDTH-1:0] wdata;
  } mem_req_t;

  state_t               state, state_nxt;
  mem_req_t             mreq;
  logic                 addr_ok;
  logic                 mem_we;
  logic [TRB_WIDTH-1:0] mem_rdata;
  logic [TRB_WIDTH-1:0] mem [TRB_DEPTH];

  always_ff @(posedge FPGA_CLK_I or negedge RST_) begin
    if (!RST_) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // One memory access per cycle; the state selects which address owns the port.
  always_comb begin
    state_nxt = state;
    ACK_O     = 1'b0;
    mreq      = '0;
    unique case (state)
      S_IDLE: begin
        if (RW_I)            state_nxt = S_WRITE;
        else if (HOST_REQ_I) state_nxt = S_HOST;
      end
      S_WRITE: begin
        mreq.we    = 1'b1;
        mreq.addr  = WRITE_ADDR_I;
        mreq.wdata = WDATA_I;
        state_nxt  = S_READ;
      end
      S_READ: begin
        mreq.addr = READ_ADDR_I;
        state_nxt = S_ACK;
      end
      S_ACK: begin
        ACK_O     = 1'b1;
        state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (!RW_I) state_nxt = S_IDLE;
      end
      S_HOST: begin
        mreq.addr = HOST_ADDR_I;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Non-power-of-2 depths leave a hole in the address space: drop writes, read zeros.
  assign addr_ok   = ({1'b0, mreq.addr} < DEPTH_W);
  assign mem_we    = mreq.we & addr_ok;
  assign mem_rdata = addr_ok ? mem[mreq.addr] : '0;

  always_ff @(posedge FPGA_CLK_I) begin
    if (mem_we) mem[mreq.addr] <= mreq.wdata;
  end

  always_ff @(posedge FPGA_CLK_I or negedge RST_) begin
    if (!RST_) begin
      RDATA_O      <= '0;
      HOST_DATA_O  <= '0;
      HOST_VALID_O <= 1'b0;
    end else begin
      HOST_VALID_O <= (state == S_HOST);
      if (state == S_READ) RDATA_O     <= mem_rdata;
      if (state == S_HOST) HOST_DATA_O <= mem_rdata;
    end
  end

`ifdef TRB_MEM_ERR_EN
  logic rw_q, err_q, err_hit;

  // rw_q low while in RELEASE with RW_I high means the tracer blipped low during ACK
  // and re-raised; that new request would otherwise be silently merged into the old one.
  always_comb begin
    err_hit = 1'b0;
    if ((state == S_WRITE || state == S_READ) && !RW_I) err_hit = 1'b1;
    if ((state == S_WRITE || state == S_READ || state == S_HOST) && !addr_ok) err_hit = 1'b1;
    if (state == S_RELEASE && RW_I && !rw_q) err_hit = 1'b1;
  end

  always_ff @(posedge FPGA_CLK_I or negedge RST_) begin
    if (!RST_) begin
      rw_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rw_q  <= RW_I;
      err_q <= err_q | err_hit;
    end
  end

  assign ERR_O = err_q;
`else
  assign ERR_O = 1'b0;
`endif

endmodule
